// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter.
// Owner tags mark which requester a response belongs to.
package mem_port_arbiter_pkg;

  localparam int   XLEN   = 32;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// One-bit owner FIFO tracking in-flight memory requests.
// Pointers wrap modulo DEPTH; count doubles as outstanding count.
module owner_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic          mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr];

  // Storage write; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-over-fetch memory port arbiter with starvation guard.
// Responses return in order and are steered by the owner FIFO.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW =
    (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [CW-1:0] outst_cnt;
  logic [SW-1:0] starve_cnt;
  logic          starve_max;
  logic          fifo_full;
  logic          fifo_empty;
  logic          head_own;
  logic          has_room;
  logic          sel_if;
  logic          sel_d;
  logic          accept;
  logic          pop;

  assign starve_max = (starve_cnt == SW'(STARVE_LIM));
  assign sel_if     = if_req & (starve_max | ~d_req);
  assign sel_d      = d_req & ~sel_if;

  assign has_room =
    (outst_cnt < CW'(MAX_OUTST)) & ~fifo_full;
  assign mem_req  = (if_req | d_req) & has_room;
  assign accept   = mem_req & mem_gnt;
  assign if_gnt   = accept & sel_if;
  assign d_gnt    = accept & sel_d;

  assign mem_we    = sel_d & d_we;
  assign mem_addr  = sel_if ? if_addr : d_addr;
  assign mem_wdata = d_wdata;

  // Byte enables: full word for fetch, none when idle.
  always_comb begin
    mem_be = 4'h0;
    unique case (1'b1)
      sel_if:  mem_be = 4'hF;
      sel_d:   mem_be = d_be;
      default: mem_be = 4'h0;
    endcase
  end

  assign pop       = mem_rvalid & ~fifo_empty;
  assign if_rvalid = pop & (head_own == OWN_IF);
  assign d_rvalid  = pop & (head_own == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (sel_d ? OWN_D : OWN_IF),
    .pop   (pop),
    .dout  (head_own),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  // Count lost fetch arbitrations until fetch is forced through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && !starve_max) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// Reference model: owner queue plus integer starvation count.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MO = 2;
  localparam int SL = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req = 0;
  logic [XLEN-1:0] if_addr = '0;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            d_req = 0;
  logic            d_we = 0;
  logic [3:0]      d_be = '0;
  logic [XLEN-1:0] d_addr = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt = 0;
  logic            mem_rvalid = 0;
  logic [XLEN-1:0] mem_rdata = '0;

  mem_port_arbiter #(
    .MAX_OUTST  (MO),
    .STARVE_LIM (SL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int lat = 1;
  int last_due = -1;
  int m_starve = 0;
  bit fix_rdata = 0;
  bit force_rv = 0;
  bit q_own[$];
  int due[$];
  bit ig, dg;
  logic [3:0] seq_d;
  logic [3:0] seq_i;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock of stimulus, checking, and model update.
  task automatic step(output bit o_ig, output bit o_dg);
    bit sel_if, sel_d, full, mreq, pop, rsp;
    logic [3:0] be;
    int t;
    rsp = (due.size() > 0) && (due[0] <= cyc_n);
    mem_rvalid = force_rv || rsp;
    mem_rdata = fix_rdata ? 32'h13 : $urandom;
    #3;
    full   = q_own.size() >= MO;
    sel_if = if_req && (m_starve == SL || !d_req);
    sel_d  = d_req && !sel_if;
    mreq   = (if_req || d_req) && !full;
    o_ig   = mreq && mem_gnt && sel_if;
    o_dg   = mreq && mem_gnt && sel_d;
    pop    = mem_rvalid && q_own.size() > 0;
    be = sel_if ? 4'hF : (sel_d ? d_be : 4'h0);
    chk("mem_req", mem_req, mreq);
    chk("if_gnt", if_gnt, o_ig);
    chk("d_gnt", d_gnt, o_dg);
    chk("if_rvalid", if_rvalid,
        pop && q_own[0] == 1'b0);
    chk("d_rvalid", d_rvalid,
        pop && q_own[0] == 1'b1);
    chk("mem_we", mem_we, sel_d && d_we);
    chk("mem_be", mem_be, be);
    if (mreq)
      chk("mem_addr", mem_addr,
          sel_if ? if_addr : d_addr);
    if (mreq && sel_d && d_we)
      chk("mem_wdata", mem_wdata, d_wdata);
    if (pop) begin
      chk("if_rdata", if_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
    end
    if (rsp) void'(due.pop_front());
    if (pop) void'(q_own.pop_front());
    if (o_ig || o_dg) begin
      q_own.push_back(o_dg);
      t = cyc_n + lat;
      if (t <= last_due) t = last_due + 1;
      due.push_back(t);
      last_due = t;
    end
    if (!if_req || o_ig) m_starve = 0;
    else if (o_dg && m_starve < SL) m_starve++;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    rst_n = 0;
    if_req = 0;
    d_req = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    @(posedge clk);
    #1;
    cyc_n++;
    rst_n = 1;
    q_own.delete();
    m_starve = 0;
  endtask

  initial begin
    rst_n = 0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state, plus a stray response with empty FIFO
    step(ig, dg);
    chk("rst_mem_req", mem_req, 1'b0);
    force_rv = 1;
    step(ig, dg);
    force_rv = 0;

    // fetch only, 1-cycle memory, fixed rdata
    fix_rdata = 1;
    lat = 1;
    mem_gnt = 1;
    if_req = 1;
    if_addr = 32'h100;
    repeat (5) step(ig, dg);
    if_req = 0;
    repeat (2) step(ig, dg);
    fix_rdata = 0;

    // both requesting: data wins, load answered on d side
    if_req = 1;
    if_addr = 32'h200;
    d_req = 1;
    d_we = 0;
    d_be = 4'hF;
    d_addr = 32'h3000;
    step(ig, dg);
    d_req = 0;
    step(ig, dg);
    if_req = 0;
    repeat (2) step(ig, dg);

    // starvation: d held, fetch wins 4th opportunity
    if_req = 1;
    d_req = 1;
    seq_d = '0;
    seq_i = '0;
    for (int i = 0; i < 4; i++) begin
      step(ig, dg);
      seq_d[i] = dg;
      seq_i[i] = ig;
    end
    chk("starve_d_seq", seq_d, 4'b0111);
    chk("starve_i_seq", seq_i, 4'b1000);
    step(ig, dg);
    chk("starve_clear", dg, 1'b1);
    if_req = 0;
    d_req = 0;
    repeat (2) step(ig, dg);

    // full at MAX_OUTST with 5-cycle responses
    lat = 5;
    if_req = 1;
    repeat (12) step(ig, dg);
    if_req = 0;
    repeat (8) step(ig, dg);

    // store passes be/wdata and is acked on d side
    lat = 1;
    d_req = 1;
    d_we = 1;
    d_be = 4'b0011;
    d_addr = 32'h40;
    d_wdata = 32'hDEADBEEF;
    step(ig, dg);
    d_req = 0;
    d_we = 0;
    repeat (2) step(ig, dg);

    // reset with 2 outstanding, late responses dropped
    lat = 4;
    if_req = 1;
    d_req = 1;
    repeat (2) step(ig, dg);
    do_reset();
    repeat (6) step(ig, dg);
    lat = 1;
    if_req = 1;
    if_addr = 32'h500;
    mem_gnt = 1;
    step(ig, dg);
    if_req = 0;
    repeat (2) step(ig, dg);

    // randomized traffic; requests held until granted
    for (int n = 0; n < 600; n++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1;
        d_we = $urandom_range(0, 1);
        d_be = 4'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 5);
      step(ig, dg);
      if (ig) if_req = 0;
      if (dg) d_req = 0;
    end
    if_req = 0;
    d_req = 0;
    repeat (10) step(ig, dg);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory port between the instruction-fetch requester and the load/store requester of the memory-access stage. It uses fixed data-over-fetch priority with a starvation guard, issues at most `MAX_OUTST` in-flight requests, and routes in-order responses back to their owner through an owner FIFO. It sits between the fetch/mem-access stages and the memory macro.

## Interface
Parameters:
- `MAX_OUTST`, default 2: maximum accepted-but-unanswered memory requests (1..4).
- `STARVE_LIM`, default 3: consecutive cycles a fetch request may lose arbitration before fetch is forced to win.

Ports:
- `clk`, in, 1: system clock. All state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `if_req`, in, 1: fetch requests a read.
- `if_addr`, in, `XLEN`: fetch address.
- `if_gnt`, out, 1: fetch request accepted this cycle.
- `if_rvalid`, out, 1: fetch response valid.
- `if_rdata`, out, `XLEN`: fetch response data.
- `d_req`, in, 1: load/store request.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_be`, in, 4: byte enables.
- `d_addr`, in, `XLEN`: data address.
- `d_wdata`, in, `XLEN`: store data.
- `d_gnt`, out, 1: data request accepted this cycle.
- `d_rvalid`, out, 1: data response valid (load data or store ack).
- `d_rdata`, out, `XLEN`: load data.
- `mem_req`, out, 1: request to memory.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, out: muxed request fields.
- `mem_gnt`, in, 1: memory accepts `mem_req` this cycle.
- `mem_rvalid`, in, 1: memory response; one per accepted request, in order.
- `mem_rdata`, in, `XLEN`: memory read data.

## Operation
- Selection is combinational from current inputs and registered state.
  - If `starve_cnt == STARVE_LIM` and `if_req`, fetch is selected.
  - Otherwise `d_req` wins over `if_req`.
- `mem_req = (if_req | d_req) & (outst_cnt < MAX_OUTST)`. Request fields come from the selected requester.
  - When no requester is selected, drive `mem_we = 0` and `mem_be = 0`. Address and data are don't-care.
  - Fetch requests drive `mem_we = 0` and `mem_be = 4'hF`.
- Acceptance: `x_gnt = mem_req & mem_gnt & selected==x`. At most one grant per cycle.
- On accept, push the owner (0 = fetch, 1 = data) into the owner FIFO.
- On `mem_rvalid`, pop the FIFO head.
  - Assert `if_rvalid` or `d_rvalid` in the same cycle according to the head. Both rdata outputs carry `mem_rdata`.
  - `mem_rvalid` with an empty FIFO is ignored: no rvalid, no state change.
- `outst_cnt` increments on accept and decrements on a valid pop. Simultaneous accept and pop leaves it unchanged.
- The full check uses the pre-pop count. At `outst_cnt == MAX_OUTST`, no accept occurs even if a response pops in the same cycle.
- `starve_cnt` update:
  - Increments, saturating at `STARVE_LIM`, when `if_req & ~if_gnt & d_gnt`.
  - Clears on `if_gnt` or when `~if_req`.
  - Holds otherwise, e.g. when blocked by full or `~mem_gnt`.
- Requesters hold request fields stable until granted. The arbiter does not re-check this.

## Timing
- Reset, while `rst_n == 0` at a clock edge:
  - `outst_cnt = 0`, `starve_cnt = 0`, owner FIFO emptied.
  - All rvalid/gnt/`mem_req` outputs 0 in the following cycle unless the inputs re-request.
- Reset mid-operation: outstanding ownership is discarded. Responses still arriving from memory are dropped by the empty-FIFO rule.
- Grant latency is 0 cycles: combinational from `mem_gnt`. Response routing is combinational from `mem_rvalid`.
- No registered datapath. The only sequential state is the counters and owner FIFO.
- The owner FIFO read pointer wraps modulo `MAX_OUTST`, and so does the write pointer.
- Fairness bound: a fetch request waits at most `STARVE_LIM+1` grant opportunities.

## Structure
- `XLEN` comes from the shared `define.sv`. Add `OWN_IF = 1'b0` and `OWN_D = 1'b1` there.
- Sub-module `owner_fifo` holds a 1-bit wide, depth-`MAX_OUTST` FIFO with push/pop, full/empty and count outputs. Its count serves as `outst_cnt`.
- The arbiter proper contains the selection logic, starvation counter and response demux.

## Test plan
- Only `if_req`, `mem_gnt = 1`, memory 1-cycle latency, `mem_rdata = 0x13` → `if_gnt` every cycle until 2 outstanding; `if_rvalid` with `if_rdata = 0x13` one cycle after each grant; `d_rvalid` stays 0.
- `if_req` and `d_req` (load) both asserted the same cycle → `d_gnt = 1`, `if_gnt = 0`; the response for that accept appears on `d_rvalid` only.
- `d_req` held continuously with `if_req`, `STARVE_LIM = 3`, responses immediate → 3 data grants, then `if_gnt` on the 4th opportunity; `starve_cnt` back to 0.
- `MAX_OUTST = 2`, responses delayed 5 cycles → `mem_req = 0` after 2 accepts; a response arriving with a pending request in the same cycle gives no accept that cycle and an accept the next cycle.
- Store with `d_be = 4'b0011` and `d_wdata = 0xDEADBEEF` → `mem_we = 1`, `mem_be = 0011`, `mem_wdata` passes through; the ack routes to `d_rvalid`.
- `rst_n = 0` for 1 cycle with 2 outstanding, then 2 late `mem_rvalid` → no `if_rvalid`/`d_rvalid`; the next fetch is accepted and answered normally.
